// File: rtl/regfile_nibble_loader_pkg.sv
// -----------------------------------------------------------------------------
// regfile_nibble_loader_pkg
// Shared definitions for the byte-stream to nibble register-file loader:
//   - default geometry constants (entry count, address width, nibble width)
//   - the loader FSM state enumeration
// -----------------------------------------------------------------------------
package regfile_nibble_loader_pkg;

    // Number of register-file entries; write addresses wrap modulo this value.
    localparam int DEPTH  = 32;
    // Register-file write-address width.
    localparam int ADDR_W = 5;
    // Register-file data width; each stream byte carries two of these.
    localparam int NIB_W  = 4;

    // Loader states. WR_LO/WR_HI each perform exactly one register-file write.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        WR_LO     = 3'd2,
        WR_HI     = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage : regfile_nibble_loader_pkg

// File: rtl/regfile_nibble_loader.sv
// -----------------------------------------------------------------------------
// regfile_nibble_loader
// Accepts a stream of bytes and writes them, low nibble first, into a
// nibble-wide register file starting at a programmable address. A load is
// requested with a single-cycle start pulse carrying the first address and
// the nibble count; the block then requests bytes one at a time, performs
// two writes per byte and pulses done once the requested count is written.
//
// Ports
//   UserCLK    in   clock, all state changes on the rising edge
//   UserRST    in   asynchronous active-high reset
//   start      in   load request, honoured only while idle
//   start_adr  in   first write address (sampled with start)
//   len        in   nibble count 0..DEPTH (sampled with start, clamped)
//   s_data     in   stream byte, low nibble written first
//   s_valid    in   stream byte valid
//   s_ready    out  stream byte accepted when s_valid && s_ready at an edge
//   W_ADR      out  register-file write address (0 when W_en is low)
//   D          out  register-file write data    (0 when W_en is low)
//   W_en       out  register-file write enable
//   busy       out  high while a load is in progress
//   done       out  one-cycle completion pulse
//
// All outputs are decoded from registered state only, so the asynchronous
// reset clears them immediately and no input reaches an output within a cycle.
// -----------------------------------------------------------------------------
module regfile_nibble_loader #(
    parameter int DEPTH  = regfile_nibble_loader_pkg::DEPTH,
    parameter int ADDR_W = regfile_nibble_loader_pkg::ADDR_W,
    parameter int NIB_W  = regfile_nibble_loader_pkg::NIB_W
) (
    input  logic                 UserCLK,
    input  logic                 UserRST,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_adr,
    input  logic [ADDR_W:0]      len,
    input  logic [2*NIB_W-1:0]   s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [ADDR_W-1:0]    W_ADR,
    output logic [NIB_W-1:0]     D,
    output logic                 W_en,
    output logic                 busy,
    output logic                 done
);

    import regfile_nibble_loader_pkg::*;

    // Nibble counter is one bit wider than the address so it can hold DEPTH.
    localparam int LEN_W = ADDR_W + 1;

    // Requests longer than the register file are limited to one full pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] res;
        if (l > LEN_W'(DEPTH)) begin
            res = LEN_W'(DEPTH);
        end else begin
            res = l;
        end
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [2*NIB_W-1:0]     byte_q, byte_d;

    logic [LEN_W-1:0]       len_eff_s;
    logic [ADDR_W-1:0]      addr_inc_s;
    logic                   last_nib_s;

    // Effective nibble count and modulo-DEPTH address increment.
    always_comb begin
        len_eff_s  = clamp_len(len);
        last_nib_s = (rem_q == LEN_W'(1));
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
            addr_inc_s = {ADDR_W{1'b0}};
        end else begin
            addr_inc_s = addr_q + ADDR_W'(1);
        end
    end

    // Next-state logic for the FSM and its address/count/byte registers.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_eff_s != {LEN_W{1'b0}}) begin
                        addr_d  = start_adr;
                        rem_d   = len_eff_s;
                        state_d = WAIT_BYTE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BYTE: begin
                if (s_valid) begin
                    byte_d  = s_data;
                    state_d = WR_LO;
                end else begin
                    state_d = WAIT_BYTE;
                end
            end
            WR_LO: begin
                addr_d = addr_inc_s;
                rem_d  = rem_q - LEN_W'(1);
                // An odd count ends here: the high nibble is dropped and no
                // further byte is requested.
                if (last_nib_s) begin
                    state_d = DONE;
                end else begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                addr_d = addr_inc_s;
                rem_d  = rem_q - LEN_W'(1);
                if (last_nib_s) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_BYTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge UserCLK or posedge UserRST) begin
        if (UserRST) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            rem_q   <= {LEN_W{1'b0}};
            byte_q  <= {(2*NIB_W){1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
        end
    end

    // Output decode from registered state; write bus held at zero when idle.
    always_comb begin
        s_ready = 1'b0;
        W_en    = 1'b0;
        W_ADR   = {ADDR_W{1'b0}};
        D       = {NIB_W{1'b0}};
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            WAIT_BYTE: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            WR_LO: begin
                W_en  = 1'b1;
                W_ADR = addr_q;
                D     = byte_q[NIB_W-1:0];
                busy  = 1'b1;
            end
            WR_HI: begin
                W_en  = 1'b1;
                W_ADR = addr_q;
                D     = byte_q[2*NIB_W-1:NIB_W];
                busy  = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule : regfile_nibble_loader

// File: tb/tb_regfile_nibble_loader.sv
// -----------------------------------------------------------------------------
// tb_regfile_nibble_loader
// Scoreboard bench: every byte driven pushes its expected (address, nibble)
// writes into a queue from a small address/count model; a negedge monitor
// pops and compares on every W_en cycle and checks the idle write bus.
// -----------------------------------------------------------------------------
module tb_regfile_nibble_loader;

    localparam int DEPTH = 32;

    logic        UserCLK   = 1'b0;
    logic        UserRST   = 1'b1;
    logic        start     = 1'b0;
    logic [4:0]  start_adr = 5'd0;
    logic [5:0]  len       = 6'd0;
    logic [7:0]  s_data    = 8'd0;
    logic        s_valid   = 1'b0;
    logic        s_ready;
    logic [4:0]  W_ADR;
    logic [3:0]  D;
    logic        W_en;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [8:0]  exp_q[$];
    int          m_addr   = 0;
    int          m_rem    = 0;

    regfile_nibble_loader dut (
        .UserCLK   (UserCLK),
        .UserRST   (UserRST),
        .start     (start),
        .start_adr (start_adr),
        .len       (len),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .W_ADR     (W_ADR),
        .D         (D),
        .W_en      (W_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 UserCLK = ~UserCLK;

    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge UserCLK) begin
        logic [8:0] e;
        if (!UserRST) begin
            if (W_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write_en", {31'd0, W_en}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("write_adr_data", {23'd0, W_ADR, D}, {23'd0, e});
                end
            end else begin
                check_eq("idle_bus_zero", {23'd0, W_ADR, D}, 32'd0);
            end
        end
    end

    // Model: queue the writes one byte produces given the remaining count.
    task automatic push_byte(input logic [7:0] b);
        logic [4:0] a;
        logic [3:0] nib;
        for (int k = 0; k < 2; k++) begin
            if (m_rem > 0) begin
                a   = 5'(m_addr);
                nib = (k == 0) ? b[3:0] : b[7:4];
                exp_q.push_back({a, nib});
                m_addr = (m_addr + 1) % DEPTH;
                m_rem--;
            end
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after it was sampled.
    task automatic start_load(input logic [4:0] adr, input logic [5:0] l);
        @(negedge UserCLK);
        start     = 1'b1;
        start_adr = adr;
        len       = l;
        m_addr    = int'(adr);
        m_rem     = (int'(l) > DEPTH) ? DEPTH : int'(l);
        @(negedge UserCLK);
        start     = 1'b0;
    endtask

    // Offer one byte until accepted; returns at the negedge after handshake.
    task automatic send_byte(input logic [7:0] b, output int hs_cyc);
        push_byte(b);
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_ready) break;
            @(negedge UserCLK);
        end
        check_eq("s_ready_for_byte", {31'd0, s_ready}, 32'd1);
        hs_cyc = cyc;
        @(negedge UserCLK);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input bit chk_prev_wen);
        logic prev;
        prev = W_en;
        for (int i = 0; i < 200; i++) begin
            @(negedge UserCLK);
            if (done) break;
            prev = W_en;
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
        if (chk_prev_wen) check_eq("write_before_done", {31'd0, prev}, 32'd1);
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge UserCLK);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("busy_after_done", {31'd0, busy}, 32'd0);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int h0, h1;

        // Reset state
        repeat (3) @(negedge UserCLK);
        check_eq("rst_outputs", {25'd0, s_ready, W_en, busy, done, 3'd0},
                 32'd0);
        check_eq("rst_bus", {23'd0, W_ADR, D}, 32'd0);
        UserRST = 1'b0;
        repeat (2) @(negedge UserCLK);

        // Basic 4-nibble load from address 0
        start_load(5'd0, 6'd4);
        check_eq("s_ready_after_start", {31'd0, s_ready}, 32'd1);
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        send_byte(8'hA5, h0);
        send_byte(8'h3C, h1);
        check_eq("throughput_3cyc", h1 - h0, 32'd3);
        wait_done(1'b1);

        // Address wrap 31 -> 0
        start_load(5'd30, 6'd4);
        send_byte(8'h21, h0);
        send_byte(8'h43, h1);
        wait_done(1'b1);

        // Odd length: last high nibble dropped, no further byte requested
        start_load(5'd5, 6'd3);
        send_byte(8'h21, h0);
        send_byte(8'h43, h1);
        check_eq("no_ready_after_last", {31'd0, s_ready}, 32'd0);
        wait_done(1'b1);
        check_eq("no_ready_idle", {31'd0, s_ready}, 32'd0);

        // Zero length: done one cycle after start, no request, no write
        start_load(5'd7, 6'd0);
        check_eq("len0_done", {31'd0, done}, 32'd1);
        check_eq("len0_no_ready", {31'd0, s_ready}, 32'd0);
        check_eq("len0_not_busy", {31'd0, busy}, 32'd0);
        @(negedge UserCLK);
        check_eq("len0_done_low", {31'd0, done}, 32'd0);
        check_eq("len0_no_ready2", {31'd0, s_ready}, 32'd0);

        // Reset during WR_HI, then a fresh load from address 0
        start_load(5'd10, 6'd4);
        send_byte(8'hB7, h0);
        @(negedge UserCLK);
        check_eq("in_wr_hi", {31'd0, W_en}, 32'd1);
        #2 UserRST = 1'b1;
        #1;
        check_eq("rst_wen_async", {31'd0, W_en}, 32'd0);
        check_eq("rst_busy_async", {31'd0, busy}, 32'd0);
        check_eq("rst_bus_async", {23'd0, W_ADR, D}, 32'd0);
        exp_q.delete();
        @(negedge UserCLK);
        UserRST = 1'b0;
        @(negedge UserCLK);
        check_eq("post_rst_idle", {30'd0, busy, s_ready}, 32'd0);
        start_load(5'd0, 6'd2);
        send_byte(8'hE1, h0);
        wait_done(1'b1);

        // Stalled stream with an ignored start in WAIT_BYTE
        start_load(5'd8, 6'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge UserCLK);
            start     = (i == 4) ? 1'b1 : 1'b0;
            start_adr = 5'd20;
            len       = 6'd2;
        end
        @(negedge UserCLK);
        start = 1'b0;
        check_eq("stall_still_ready", {31'd0, s_ready}, 32'd1);
        send_byte(8'h76, h0);
        send_byte(8'h98, h1);
        wait_done(1'b1);

        // Over-length request clamps to a full 32-nibble pass with wrap
        start_load(5'd3, 6'd40);
        for (int k = 0; k < 16; k++) begin
            send_byte(8'((k * 17 + 9) & 255), h1);
            if (k > 0) check_eq("throughput_clamp", h1 - h0, 32'd3);
            h0 = h1;
        end
        check_eq("clamp_no_more_ready", {31'd0, s_ready}, 32'd0);
        wait_done(1'b1);

        repeat (3) @(negedge UserCLK);
        check_eq("final_scoreboard", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_nibble_loader

// File: doc/regfile_nibble_loader.md
REGFILE_NIBBLE_LOADER -- requirements
Module: regfile_nibble_loader

Interface
REQ-001 Parameters SHALL be: DEPTH, default 32, number of register-file entries; ADDR_W, default 5, write-address width; NIB_W, default 4, register-file data width.
REQ-002 Port UserCLK SHALL be: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port UserRST SHALL be: input, 1 bit, reset, asynchronous, active-high.
REQ-004 Port start SHALL be: input, 1 bit, load-request pulse, sampled only in IDLE.
REQ-005 Port start_adr SHALL be: input, ADDR_W bits, first write address, sampled with start.
REQ-006 Port len SHALL be: input, ADDR_W+1 bits, nibble count 0..32, sampled with start; values above 32 are treated as 32.
REQ-007 Port s_data SHALL be: input, 2*NIB_W bits, byte stream data, low nibble first.
REQ-008 Port s_valid SHALL be: input, 1 bit, s_data valid.
REQ-009 Port s_ready SHALL be: output, 1 bit, byte accepted on any edge where s_valid and s_ready are both 1.
REQ-010 Port W_ADR SHALL be: output, ADDR_W bits, register-file write address.
REQ-011 Port D SHALL be: output, NIB_W bits, register-file write data.
REQ-012 Port W_en SHALL be: output, 1 bit, register-file write enable.
REQ-013 Port busy SHALL be: output, 1 bit, high in WAIT_BYTE, WR_LO and WR_HI.
REQ-014 Port done SHALL be: output, 1 bit, one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_BYTE, WR_LO, WR_HI and DONE.
REQ-016 IDLE SHALL respond to start as follows: with effective len != 0, load addr=start_adr and remaining=len and go to WAIT_BYTE; with len == 0, go to DONE.
REQ-017 WAIT_BYTE SHALL drive s_ready=1; on handshake it SHALL capture s_data into a byte register and go to WR_LO; with s_valid=0 it SHALL hold indefinitely with no writes.
REQ-018 WR_LO SHALL drive W_en=1, W_ADR=addr and D=byte[3:0], then increment addr and decrement remaining; if remaining was 1 it SHALL go to DONE, else to WR_HI.
REQ-019 WR_HI SHALL drive W_en=1, W_ADR=addr and D=byte[7:4], then increment addr and decrement remaining; if remaining was 1 it SHALL go to DONE, else to WAIT_BYTE.
REQ-020 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-021 addr SHALL wrap modulo DEPTH (31 -> 0).
REQ-022 With odd len, the final byte's high nibble SHALL be discarded, and no further byte SHALL be requested.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 s_ready, W_en, W_ADR, D, busy and done SHALL be decoded from registered state only, with no combinational path from any input.
REQ-025 Throughput SHALL be one byte per 3 cycles when s_valid is held high.
REQ-026 Latency SHALL be: s_ready rises 1 cycle after start is sampled; the first write occurs in the cycle after the byte handshake.
REQ-027 W_ADR and D SHALL be 0 whenever W_en=0.

Reset
REQ-028 UserRST=1 SHALL immediately force state=IDLE, addr=0, remaining=0 and byte=0.
REQ-029 UserRST=1 SHALL immediately force all outputs to 0, including mid-write.
REQ-030 After reset release, the first start SHALL behave identically to a start after power-up; no partial load SHALL resume.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the constants DEPTH=32, ADDR_W=5 and NIB_W=4.
REQ-032 The block SHALL be a single module with no sub-module; the address/remaining counters are kept inline.

Verification
REQ-033 start_adr=0, len=4, bytes 0xA5 then 0x3C -> writes (0,5),(1,A),(2,C),(3,3); done pulses the cycle after the last write; busy then falls.
REQ-034 start_adr=30, len=4, bytes 0x21 then 0x43 -> writes (30,1),(31,2),(0,3),(1,4).
REQ-035 start_adr=5, len=3, bytes 0x21 then 0x43 -> writes (5,1),(6,2),(7,3); nibble 4 is never written; s_ready stays 0 after the second byte is accepted.
REQ-036 len=0 -> W_en never asserted; done pulses 1 cycle after start is sampled; s_ready stays 0.
REQ-037 UserRST pulsed while in WR_HI -> W_en and busy drop without waiting for a clock edge; a subsequent start with start_adr=0, len=2 writes from address 0 correctly.
REQ-038 s_valid held low for 10 cycles in WAIT_BYTE, with start pulsed during that time -> no writes occur, the start is ignored, and addr and remaining are unchanged.
